// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared widths, derived constants and FSM states for the median accelerator
package median_pkg;
  localparam int A_WIDTH   = 8;
  localparam int D_WIDTH   = 8;
  localparam int R_WIDTH   = 3;
  localparam int W_WIDTH   = A_WIDTH - R_WIDTH;
  localparam int WIN_SIZE  = 1 << R_WIDTH;
  localparam int WIN_COUNT = 1 << W_WIDTH;
  localparam int MA_WORDS  = 1 << (A_WIDTH - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SORT,
    ST_WRITE,
    ST_DONE
  } state_t;
endpackage

// File: rtl/median_if.sv
// rtl/median_if.sv - host-side control and memory-port bundle of the median accelerator
interface median_if import median_pkg::*; ();
  logic                 Go_t;
  logic                 Done_t;
  logic [31:0]          MA_di32;
  logic [A_WIDTH-3:0]   MA_Addr6;
  logic                 MA_enb;
  logic                 MA_web;
  logic [31:0]          MA_do32;
  logic [D_WIDTH-1:0]   MA_di8;
  logic [W_WIDTH-1:0]   MO_Addr5b;
  logic                 MO_enb;
  logic                 MO_web;
  logic [D_WIDTH-1:0]   MO_di8b;
  logic [D_WIDTH-1:0]   MO_do8b;
  logic [D_WIDTH-1:0]   MO_do8;

  modport master (
    output Go_t, MA_di32, MA_Addr6, MA_enb, MA_web, MO_Addr5b, MO_enb, MO_web, MO_di8b,
    input  Done_t, MA_do32, MA_di8, MO_do8b, MO_do8
  );

  modport slave (
    input  Go_t, MA_di32, MA_Addr6, MA_enb, MA_web, MO_Addr5b, MO_enb, MO_web, MO_di8b,
    output Done_t, MA_do32, MA_di8, MO_do8b, MO_do8
  );
endinterface

// File: rtl/median_core.sv
// rtl/median_core.sv - window fetch, odd-even transposition sort and median write-back FSM
module median_core import median_pkg::*; (
  input  logic               Clk,
  input  logic               Rst_Core,
  input  logic               Go_t,
  output logic               Done_t,
  output logic [A_WIDTH-1:0] rd_addr,
  input  logic [D_WIDTH-1:0] rd_data,
  output logic               wr_en,
  output logic [W_WIDTH-1:0] wr_addr,
  output logic [D_WIDTH-1:0] wr_data
);
  localparam int CW = R_WIDTH + 1;
  localparam logic [CW-1:0]      FETCH_LAST = CW'(WIN_SIZE);
  localparam logic [CW-1:0]      SORT_LAST  = CW'(WIN_SIZE - 1);
  localparam logic [W_WIDTH-1:0] WIN_LAST   = W_WIDTH'(WIN_COUNT - 1);

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [W_WIDTH-1:0]   win;
  logic [D_WIDTH-1:0]   arr [WIN_SIZE];
  logic [D_WIDTH:0]     mid_sum;

  always_ff @(posedge Clk or posedge Rst_Core) begin
    if (Rst_Core) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (Go_t) state_nxt = ST_FETCH;
      ST_FETCH: if (cnt == FETCH_LAST) state_nxt = ST_SORT;
      ST_SORT:  if (cnt == SORT_LAST) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = (win == WIN_LAST) ? ST_DONE : ST_FETCH;
      ST_DONE:  if (Go_t) state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Read data lags its address by one cycle, so fetch step n captures byte n-1.
  always_ff @(posedge Clk or posedge Rst_Core) begin
    if (Rst_Core) begin
      cnt <= '0;
      win <= '0;
      arr <= '{default: '0};
    end else begin
      case (state)
        ST_FETCH: begin
          if (cnt != '0) arr[R_WIDTH'(cnt - 1'b1)] <= rd_data;
          cnt <= (cnt == FETCH_LAST) ? '0 : cnt + 1'b1;
        end
        ST_SORT: begin
          if (!cnt[0]) begin
            for (int k = 0; k < WIN_SIZE; k += 2)
              if (arr[k] > arr[k+1]) begin
                arr[k]   <= arr[k+1];
                arr[k+1] <= arr[k];
              end
          end else begin
            for (int k = 1; k < WIN_SIZE - 1; k += 2)
              if (arr[k] > arr[k+1]) begin
                arr[k]   <= arr[k+1];
                arr[k+1] <= arr[k];
              end
          end
          cnt <= (cnt == SORT_LAST) ? '0 : cnt + 1'b1;
        end
        ST_WRITE: win <= win + 1'b1;
        default: begin
          cnt <= '0;
          win <= '0;
        end
      endcase
    end
  end

  assign mid_sum = {1'b0, arr[WIN_SIZE/2-1]} + {1'b0, arr[WIN_SIZE/2]};
  assign wr_data = mid_sum[D_WIDTH:1];
  assign wr_addr = win;
  assign wr_en   = (state == ST_WRITE);
  assign rd_addr = {win, cnt[R_WIDTH-1:0]};
  assign Done_t  = (state == ST_DONE);
endmodule

// File: rtl/median_top.sv
// rtl/median_top.sv - median accelerator: MemA input RAM, median core and MemO result RAM
module median_top import median_pkg::*; (
  input  logic     Clk,
  input  logic     Rst_Core,
  input  logic     Rst_M,
  median_if.slave  host
);
  logic [31:0]        mem_a [MA_WORDS];
  logic [D_WIDTH-1:0] mem_o [WIN_COUNT];
  logic [31:0]        a_word;
  logic [A_WIDTH-1:0] core_rd_addr;
  logic               core_wr_en;
  logic [W_WIDTH-1:0] core_wr_addr;
  logic [D_WIDTH-1:0] core_wr_data;

  median_core u_core (
    .Clk      (Clk),
    .Rst_Core (Rst_Core),
    .Go_t     (host.Go_t),
    .Done_t   (host.Done_t),
    .rd_addr  (core_rd_addr),
    .rd_data  (host.MA_di8),
    .wr_en    (core_wr_en),
    .wr_addr  (core_wr_addr),
    .wr_data  (core_wr_data)
  );

  always_ff @(posedge Clk) begin
    if (host.MA_enb && host.MA_web) mem_a[host.MA_Addr6] <= host.MA_di32;
  end

  // Host write is last so it wins a same-address collision with the core.
  always_ff @(posedge Clk) begin
    if (core_wr_en) mem_o[core_wr_addr] <= core_wr_data;
    if (host.MO_enb && host.MO_web) mem_o[host.MO_Addr5b] <= host.MO_di8b;
  end

  assign a_word = mem_a[core_rd_addr[A_WIDTH-1:2]];

  always_ff @(posedge Clk or posedge Rst_M) begin
    if (Rst_M) begin
      host.MA_do32 <= '0;
      host.MA_di8  <= '0;
      host.MO_do8b <= '0;
      host.MO_do8  <= '0;
    end else begin
      if (host.MA_enb && !host.MA_web) host.MA_do32 <= mem_a[host.MA_Addr6];
      if (host.MO_enb && !host.MO_web) host.MO_do8b <= mem_o[host.MO_Addr5b];
      host.MA_di8 <= a_word[{core_rd_addr[1:0], 3'b000} +: D_WIDTH];
      host.MO_do8 <= mem_o[core_wr_addr];
    end
  end
endmodule

// File: tb/tb_median_top.sv
// tb/tb_median_top.sv - directed self-checking bench for median_top
module tb_median_top;
  import median_pkg::*;

  typedef logic [7:0] med_arr_t [WIN_COUNT];

  logic Clk = 1'b0;
  logic Rst_Core;
  logic Rst_M;
  int   n_checks = 0;
  int   n_errors = 0;
  med_arr_t exp_ramp, exp_set2;
  logic [7:0] rd;

  median_if bus ();

  median_top dut (
    .Clk      (Clk),
    .Rst_Core (Rst_Core),
    .Rst_M    (Rst_M),
    .host     (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ma_write(input int w, input logic [31:0] d);
    bus.MA_enb = 1'b1; bus.MA_web = 1'b1;
    bus.MA_Addr6 = 6'(w); bus.MA_di32 = d;
    tick();
    bus.MA_enb = 1'b0; bus.MA_web = 1'b0;
  endtask

  task automatic mo_write(input int a, input logic [7:0] d);
    bus.MO_enb = 1'b1; bus.MO_web = 1'b1;
    bus.MO_Addr5b = 5'(a); bus.MO_di8b = d;
    tick();
    bus.MO_enb = 1'b0; bus.MO_web = 1'b0;
  endtask

  task automatic mo_read(input int a, output logic [7:0] d);
    bus.MO_enb = 1'b1; bus.MO_web = 1'b0; bus.MO_Addr5b = 5'(a);
    tick();
    d = bus.MO_do8b;
    bus.MO_enb = 1'b0;
  endtask

  task automatic go();
    bus.Go_t = 1'b1;
    tick();
    bus.Go_t = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.Done_t && n < 600) begin
      tick();
      n++;
    end
    check(tag, {31'b0, (bus.Done_t === 1'b1) && (n <= 580)}, 32'd1);
  endtask

  task automatic check_all(input string tag, input med_arr_t exp);
    logic [7:0] v;
    for (int i = 0; i < WIN_COUNT; i++) begin
      mo_read(i, v);
      check($sformatf("%s[%0d]", tag, i), {24'b0, v}, {24'b0, exp[i]});
    end
  endtask

  initial begin
    bus.Go_t = 0; bus.MA_di32 = 0; bus.MA_Addr6 = 0; bus.MA_enb = 0; bus.MA_web = 0;
    bus.MO_Addr5b = 0; bus.MO_enb = 0; bus.MO_web = 0; bus.MO_di8b = 0;
    Rst_Core = 1'b1; Rst_M = 1'b1;
    for (int i = 0; i < WIN_COUNT; i++) exp_ramp[i] = 8'(8 * i + 3);
    exp_set2 = exp_ramp;
    exp_set2[0] = 8'h04; exp_set2[1] = 8'h04; exp_set2[2] = 8'hFF;
    exp_set2[3] = 8'h7F; exp_set2[4] = 8'h4B;

    tick(); tick();
    check("rst_done",   {31'b0, bus.Done_t}, 32'd0);
    check("rst_ma_do",  bus.MA_do32, 32'd0);
    check("rst_mo_dob", {24'b0, bus.MO_do8b}, 32'd0);
    check("rst_mo_do",  {24'b0, bus.MO_do8}, 32'd0);
    check("rst_ma_di8", {24'b0, bus.MA_di8}, 32'd0);
    check("rst_state",  32'(dut.u_core.state), 32'(ST_IDLE));
    Rst_Core = 1'b0; Rst_M = 1'b0;
    tick();

    // Ramp: byte n holds n
    for (int w = 0; w < MA_WORDS; w++)
      ma_write(w, {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    bus.MA_enb = 1'b1; bus.MA_web = 1'b0; bus.MA_Addr6 = 6'd5;
    tick();
    bus.MA_enb = 1'b0;
    check("ma_read5", bus.MA_do32, 32'h17161514);

    go();
    check("run1_done_lo", {31'b0, bus.Done_t}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      tick();
      check($sformatf("ramp_byte%0d", b), {24'b0, bus.MA_di8}, 32'(b));
    end
    wait_done("run1_done");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("run1_done_hold", {31'b0, bus.Done_t}, 32'd1);
    end
    check_all("ramp", exp_ramp);

    // Read latency and hold with MO_enb low
    mo_read(5, rd);
    check("mo_rd5", {24'b0, rd}, 32'h2B);
    bus.MO_enb = 1'b0; bus.MO_Addr5b = 5'd6;
    tick();
    check("mo_hold", {24'b0, bus.MO_do8b}, 32'h2B);
    bus.MO_enb = 1'b1; bus.MO_Addr5b = 5'd7;
    check("mo_pre_edge", {24'b0, bus.MO_do8b}, 32'h2B);
    tick();
    bus.MO_enb = 1'b0;
    check("mo_rd7", {24'b0, bus.MO_do8b}, 32'h3B);

    go();
    check("run2_done_lo", {31'b0, bus.Done_t}, 32'd0);
    wait_done("run2_done");
    check_all("rerun", exp_ramp);

    // Directed windows 0..4, remaining windows keep the ramp
    ma_write(0, 32'h04030201); ma_write(1, 32'h08070605);
    ma_write(2, 32'h02070108); ma_write(3, 32'h04050306);
    ma_write(4, 32'hFFFFFFFF); ma_write(5, 32'hFFFFFFFF);
    ma_write(6, 32'hFF00FF00); ma_write(7, 32'hFF00FF00);
    ma_write(8, 32'h0A6405C8); ma_write(9, 32'h963201FA);
    go();
    for (int b = 0; b < 4; b++) begin
      tick();
      check($sformatf("endian_byte%0d", b), {24'b0, bus.MA_di8}, 32'(b + 1));
    end
    wait_done("run3_done");
    check_all("set2", exp_set2);

    // Abort mid-run
    mo_write(31, 8'h00);
    go();
    for (int i = 0; i < 99; i++) tick();
    Rst_Core = 1'b1;
    #1;
    check("abort_done", {31'b0, bus.Done_t}, 32'd0);
    check("abort_state", 32'(dut.u_core.state), 32'(ST_IDLE));
    tick();
    Rst_Core = 1'b0;
    mo_read(0, rd);
    check("abort_kept0", {24'b0, rd}, 32'h04);
    mo_read(31, rd);
    check("abort_untouched31", {24'b0, rd}, 32'h00);
    for (int i = 0; i < 20; i++) tick();
    check("abort_stays_idle", {31'b0, bus.Done_t}, 32'd0);
    go();
    wait_done("run4_done");
    check_all("after_abort", exp_set2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
